// File: rtl/audio_mixer_nch_if.sv
// rtl/audio_mixer_nch_if.sv - sample strobe, channel/gain/level inputs and mixed outputs of the N-channel mixer
interface audio_mixer_nch_if #(
    parameter int NCH  = 4,
    parameter int IW   = 8,
    parameter int GW   = 4,
    parameter int NBIT = 3,
    parameter int OW   = 16
);
    localparam int NB = (NBIT > 0) ? NBIT : 1;

    logic                  sample_stb;
    logic [NCH*IW-1:0]     ch_in;
    logic [NCH*GW-1:0]     gain_l;
    logic [NCH*GW-1:0]     gain_r;
    logic [NB-1:0]         bit_in;
    logic [NB*(OW-1)-1:0]  bit_lvl;
    logic [OW-1:0]         audio_l;
    logic [OW-1:0]         audio_r;
    logic                  out_valid;
    logic                  busy;
    logic                  overrun;
    logic                  clip;

    modport master (
        output sample_stb, ch_in, gain_l, gain_r, bit_in, bit_lvl,
        input  audio_l, audio_r, out_valid, busy, overrun, clip
    );

    modport slave (
        input  sample_stb, ch_in, gain_l, gain_r, bit_in, bit_lvl,
        output audio_l, audio_r, out_valid, busy, overrun, clip
    );
endinterface

// File: rtl/audio_mixer_nch.sv
// rtl/audio_mixer_nch.sv - time-multiplexed stereo mixer of NCH multi-bit channels plus NBIT one-bit sources
// One channel is scaled and accumulated per clock; the result is clipped to the positive half-range.
module audio_mixer_nch #(
    parameter int NCH  = 4,
    parameter int IW   = 8,
    parameter int GW   = 4,
    parameter int NBIT = 3,
    parameter int OW   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    audio_mixer_nch_if.slave   bus
);
    localparam int NB  = (NBIT > 0) ? NBIT : 1;
    localparam int LW  = OW - 1;
    localparam int EW  = OW - 3;
    localparam int PW  = EW + GW;
    localparam int TW  = PW - 3;
    localparam int AW  = OW + $clog2(NCH) + 1;
    localparam int IXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW-1:0] MAXV = {{(AW-LW){1'b0}}, {LW{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_BITS, S_SAT} state_t;

    state_t                state_q, state_d;
    logic [IXW-1:0]        idx_q, idx_d;
    logic [NCH*IW-1:0]     ch_q, ch_d;
    logic [NCH*GW-1:0]     gl_q, gl_d;
    logic [NCH*GW-1:0]     gr_q, gr_d;
    logic [NB-1:0]         bit_q, bit_d;
    logic [NB*LW-1:0]      lvl_q, lvl_d;
    logic [AW-1:0]         acc_l_q, acc_l_d;
    logic [AW-1:0]         acc_r_q, acc_r_d;
    logic [OW-1:0]         audio_l_q, audio_l_d;
    logic [OW-1:0]         audio_r_q, audio_r_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  clip_q, clip_d;

    logic [IW-1:0]         samp;
    logic [EW-1:0]         esamp;
    logic [GW-1:0]         g_l, g_r;
    logic [PW-1:0]         prod_l, prod_r;
    logic [AW-1:0]         bits_sum;
    logic                  sat_l, sat_r;

    // Widen a sample to EW bits by repeating it MSB-first, so full scale maps to all ones.
    function automatic logic [EW-1:0] expand(input logic [IW-1:0] s);
        logic [EW-1:0] e;
        e = '0;
        for (int i = 0; i < EW; i++) begin
            e[EW-1-i] = s[IW-1-(i % IW)];
        end
        return e;
    endfunction

    always_comb begin
        samp   = ch_q[idx_q*IW +: IW];
        g_l    = gl_q[idx_q*GW +: GW];
        g_r    = gr_q[idx_q*GW +: GW];
        esamp  = expand(samp);
        prod_l = {{GW{1'b0}}, esamp} * {{EW{1'b0}}, g_l};
        prod_r = {{GW{1'b0}}, esamp} * {{EW{1'b0}}, g_r};
    end

    always_comb begin
        bits_sum = '0;
        for (int j = 0; j < NBIT; j++) begin
            if (bit_q[j]) begin
                bits_sum = bits_sum + {{(AW-LW){1'b0}}, lvl_q[j*LW +: LW]};
            end
        end
    end

    assign sat_l = (acc_l_q > MAXV);
    assign sat_r = (acc_r_q > MAXV);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        gl_d      = gl_q;
        gr_d      = gr_q;
        bit_d     = bit_q;
        lvl_d     = lvl_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        valid_d   = 1'b0;
        clip_d    = clip_q;
        overrun_d = bus.sample_stb && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.sample_stb) begin
                    ch_d    = bus.ch_in;
                    gl_d    = bus.gain_l;
                    gr_d    = bus.gain_r;
                    bit_d   = bus.bit_in;
                    lvl_d   = bus.bit_lvl;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_l_d = acc_l_q + {{(AW-TW){1'b0}}, prod_l[PW-1:3]};
                acc_r_d = acc_r_q + {{(AW-TW){1'b0}}, prod_r[PW-1:3]};
                if (idx_q == IXW'(NCH-1)) begin
                    state_d = S_BITS;
                end else begin
                    idx_d = idx_q + IXW'(1);
                end
            end
            S_BITS: begin
                acc_l_d = acc_l_q + bits_sum;
                acc_r_d = acc_r_q + bits_sum;
                state_d = S_SAT;
            end
            S_SAT: begin
                audio_l_d = sat_l ? MAXV[OW-1:0] : acc_l_q[OW-1:0];
                audio_r_d = sat_r ? MAXV[OW-1:0] : acc_r_q[OW-1:0];
                valid_d   = 1'b1;
                clip_d    = clip_q | sat_l | sat_r;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ch_q      <= '0;
            gl_q      <= '0;
            gr_q      <= '0;
            bit_q     <= '0;
            lvl_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ch_q      <= ch_d;
            gl_q      <= gl_d;
            gr_q      <= gr_d;
            bit_q     <= bit_d;
            lvl_q     <= lvl_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            clip_q    <= clip_d;
        end
    end

    assign bus.audio_l   = audio_l_q;
    assign bus.audio_r   = audio_r_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.clip      = clip_q;
endmodule
